apb_slave_mem: RTL
==================

# apb_slave_mem

APB completer (slave) that sits directly downstream of the two-slave APB bridge. It terminates one PSEL line and services 8-bit read/write transfers against a local register-file memory. A configurable number of wait states is inserted through PREADY. Out-of-range addresses complete with PSLVERR. Two instances, one per PSEL, form the bridge's slave side.

## Interface
Parameters:
- ADDR_WIDTH, 8: width of PADDR.
- DATA_WIDTH, 8: width of PWDATA and PRDATA.
- DEPTH, 64: number of memory words. Legal addresses are 0..DEPTH-1.
- WAIT_CYCLES, 1: number of PREADY-low cycles in ACCESS before completion. Range 0..15.

Ports:
- PCLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- PSEL  in  1  slave select from the bridge.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  transfer address.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data. Valid only when PREADY=1 on a read.
- PREADY  out  1  transfer-complete strobe.
- PSLVERR  out  1  error. Valid only when PREADY=1.

## Operation
- FSM states are IDLE and ACCESS. A 4-bit wait counter `cnt` runs alongside them.
- **IDLE:**
  - Setup is detected when PSEL=1 and PENABLE=0.
  - On setup, capture `addr_q`, `wr_q` and `wdata_q` from PADDR, PWRITE and PWDATA.
  - Also on setup: set `err_q = (PADDR >= DEPTH)`, load `cnt = WAIT_CYCLES`, and go to ACCESS.
  - PSEL=1 with PENABLE=1 while in IDLE is a protocol violation. It is ignored and the FSM stays in IDLE.
- **ACCESS:**
  - If PSEL=0, abort: go to IDLE, commit no write, PREADY stays 0.
  - Otherwise, if cnt≠0, decrement cnt.
  - Otherwise (cnt=0), PREADY=1 this cycle and the next state is IDLE.
  - A write commits `mem[addr_q] <= wdata_q` at the completion edge, only if `err_q=0`.
- **Outputs:**
  - PREADY = (state==ACCESS && cnt==0 && PSEL). PREADY is a decode of registered state, with no combinational path from PWDATA or PADDR.
  - PRDATA = mem[addr_q] when PREADY && !wr_q && !err_q, else 0.
  - PSLVERR = PREADY && err_q.
- An error write leaves memory unchanged. An error read returns PRDATA=0.
- Address and control are taken from the captured registers. Changes to PADDR, PWRITE or PWDATA during ACCESS have no effect.

## Timing
- **Reset** (RST=0, asynchronous):
  - state=IDLE, cnt=0, every mem word=0, all capture registers=0.
  - PREADY=0, PSLVERR=0, PRDATA=0.
- Reset asserted mid-ACCESS kills the transfer with no write.
- **Latency:**
  - Setup at edge N, so the FSM is in ACCESS from N+1.
  - PREADY=1 during cycle N+1+WAIT_CYCLES.
  - With WAIT_CYCLES=0, PREADY=1 in the first ACCESS cycle (zero-wait APB).
- **Back-to-back:** a new setup in the cycle right after completion is accepted from IDLE. The resulting throughput is one transfer per WAIT_CYCLES+2 cycles.
- **Read-after-write** to the same address in consecutive transfers returns the new data.
- **Boundaries:**
  - addr=DEPTH-1 is legal.
  - addr=DEPTH through 2^ADDR_WIDTH-1 gives an error.
  - Memory index uses clog2(DEPTH) bits of `addr_q`. No wrap-around into legal space is permitted.

## Structure
- Package `apb_pkg` holds:
  - `apb_state_e` {IDLE, ACCESS}
  - APB_ADDR_W=8 and APB_DATA_W=8
  - the width of the wait counter
- Sub-module `apb_slave_regfile`:
  - DEPTH×DATA_WIDTH flop array with async active-low clear.
  - One write port (we, waddr, wdata) and one combinational read port (raddr → rdata).
- The top level holds the FSM, the counter, the capture registers and the output decode.

## Test plan
- **Reset:** hold RST=0 for 3 cycles, release → PREADY=0, PSLVERR=0, PRDATA=0; read addr 0x05 → 0x00.
- **Write then read:** with WAIT_CYCLES=1, write 0xA5 to 0x10, then read 0x10 → PREADY rises on the 2nd ACCESS cycle and the read returns PRDATA=0xA5 with PSLVERR=0.
- **Error address:** write 0x3C to 0x40 (DEPTH=64) → PSLVERR=1 on the PREADY cycle; then read 0x00 through 0x3F → 0x3C appears nowhere.
- **Zero wait:** with WAIT_CYCLES=0, run back-to-back writes to 0x3F then 0x00, then reads → PREADY in the first ACCESS cycle of each transfer; reads return the written data; each transfer takes 2 cycles.
- **Abort:** drop PSEL mid-wait in a write of 0x77 to 0x20 → no PREADY, FSM in IDLE, read 0x20 returns its old value.
- **Async reset mid-ACCESS:** assert RST during a write of 0x99 to 0x08 → outputs are 0 immediately, and after release a read of 0x08 → 0x00.

Source files
------------

// File: rtl/apb_slave_mem_pkg.sv
// Shared types and widths for the APB completer slice.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;
    // Wide enough for WAIT_CYCLES up to 15.
    localparam int APB_CNT_W  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the bridge (master side) and one completer (slave side).
interface apb_slave_mem_if
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_W,
    parameter int DATA_WIDTH = APB_DATA_W
);

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_slave_mem_regfile.sv
// DEPTH x DATA_WIDTH flop array: one synchronous write port, one combinational read port.
module apb_slave_regfile #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [IDX_W-1:0]      i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Storage: whole array clears on reset, single word written per cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer terminating one PSEL line of the bridge, backed by a local register file.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transfer; waits for setup (PSEL=1, PENABLE=0)
// ACCESS | transfer captured; counts wait states, then completes
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = APB_ADDR_W,
    parameter int DATA_WIDTH  = APB_DATA_W,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              PCLK,
    input  logic              RST,
    apb_slave_mem_if.slave    bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0]    DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [APB_CNT_W-1:0]   WAIT_LOAD = APB_CNT_W'(WAIT_CYCLES);

    apb_state_e            r_state;
    logic [APB_CNT_W-1:0]  r_cnt;
    // Only the index bits are kept; anything above them is folded into r_err at setup.
    logic [IDX_W-1:0]      r_addr;
    logic                  r_wr;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_setup;
    logic                  w_ready;
    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_setup = (r_state == IDLE) && bus.PSEL && !bus.PENABLE;
    assign w_ready = (r_state == ACCESS) && (r_cnt == '0) && bus.PSEL;
    assign w_we    = w_ready && r_wr && !r_err;

    // Transfer FSM with wait counter and setup-phase capture registers.
    always_ff @(posedge PCLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // PSEL with PENABLE already high is not a setup; it is ignored.
                    if (w_setup) begin
                        r_addr  <= bus.PADDR[IDX_W-1:0];
                        r_wr    <= bus.PWRITE;
                        r_wdata <= bus.PWDATA;
                        r_err   <= ({1'b0, bus.PADDR} >= DEPTH_LIM);
                        r_cnt   <= WAIT_LOAD;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!bus.PSEL) begin
                        r_state <= IDLE;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - APB_CNT_W'(1);
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    apb_slave_regfile #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .i_clk   (PCLK),
        .i_rst_n (RST),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata (r_wdata),
        .i_raddr (r_addr),
        .o_rdata (w_rdata)
    );

    assign bus.PREADY  = w_ready;
    assign bus.PSLVERR = w_ready && r_err;
    assign bus.PRDATA  = (w_ready && !r_wr && !r_err) ? w_rdata : '0;

endmodule
